// File: rtl/cache_fill_ctrl.sv
// Miss-handling front end for a read-only direct-mapped cache: lookup, Avalon-MM
// refill on miss, cache write-back of the fetched word, and saturating hit/miss counters.
module cache_fill_ctrl #(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BIT_TOTAL-1:0]  req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [SIZE_BLOCK-1:0] resp_data,
    output logic                  cache_en,
    output logic                  cache_wrt,
    output logic [BIT_TOTAL-1:0]  cache_addr,
    output logic [SIZE_BLOCK-1:0] cache_wdata,
    input  logic [SIZE_BLOCK-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_read,
    output logic [BIT_TOTAL-1:0]  mem_address,
    input  logic                  mem_waitrequest,
    input  logic [SIZE_BLOCK-1:0] mem_readdata,
    input  logic                  mem_readdatavalid,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } state_t;

    state_t                r_state;
    logic [BIT_TOTAL-1:0]  r_addr;
    logic [SIZE_BLOCK-1:0] r_data;
    logic [SIZE_BLOCK-1:0] r_resp_data;
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;
    logic                  w_cache_act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_resp_data <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: r_state <= CHECK;
                CHECK: begin
                    if (cache_hit) begin
                        r_data      <= cache_rdata;
                        r_resp_data <= cache_rdata;
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_state     <= RESP;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_state     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (!mem_waitrequest) r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_readdatavalid) begin
                        r_data  <= mem_readdata;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    // response word is only updated on entry to RESP so it never moves outside RESP
                    r_resp_data <= r_data;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (resp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_cache_act = (r_state == LOOKUP) || (r_state == FILL);

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign resp_data   = r_resp_data;
    assign cache_en    = w_cache_act;
    assign cache_wrt   = (r_state == FILL);
    assign cache_addr  = w_cache_act ? r_addr : '0;
    assign cache_wdata = (r_state == FILL) ? r_data : '0;
    assign mem_read    = (r_state == MEM_REQ);
    assign mem_address = (r_state == MEM_REQ) ? r_addr : '0;
    assign hit_count   = r_hit_cnt;
    assign miss_count  = r_miss_cnt;

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling front end for the read-only direct-mapped cache (clk, rst, en, wrt, i_addr, i_data, o_data, o_success; one-cycle registered lookup).
- Accepts one word read request at a time and performs a cache lookup. On a hit it returns the cached word. On a miss it fetches the word from external memory over an Avalon-MM pipelined read port, writes it into the cache, then returns it.
- Also keeps saturating hit/miss counters for performance tuning of the raytracer memory path.

Parameters:
SIZE_BLOCK, 32, data word width in bits (matches cache block size)
BIT_TOTAL, 24, word address width (cache and memory)
CNT_W, 16, width of hit/miss counters

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  requester has a read request
req_ready  output  1  controller can accept a request
req_addr  input  BIT_TOTAL  requested word address
resp_valid  output  1  response word available
resp_ready  input  1  requester consumes response
resp_data  output  SIZE_BLOCK  returned word
cache_en  output  1  to cache en
cache_wrt  output  1  to cache wrt
cache_addr  output  BIT_TOTAL  to cache i_addr
cache_wdata  output  SIZE_BLOCK  to cache i_data
cache_rdata  input  SIZE_BLOCK  from cache o_data
cache_hit  input  1  from cache o_success
mem_read  output  1  Avalon read request
mem_address  output  BIT_TOTAL  Avalon word address
mem_waitrequest  input  1  Avalon stall
mem_readdata  input  SIZE_BLOCK  Avalon read data
mem_readdatavalid  input  1  Avalon read data valid
hit_count  output  CNT_W  number of hits since reset
miss_count  output  CNT_W  number of misses since reset

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; addr_q, data_q and both counters clear to 0.
  - Every output reads 0, except req_ready=1 once in IDLE.
  - Reset mid-transaction aborts it: mem_read drops immediately, and no cache write or response follows.
  - A readdatavalid belonging to the aborted read, arriving after reset release, is ignored because the FSM is in IDLE.
- FSM states: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready=1.
  - On req_valid at the edge, latch addr_q=req_addr, go to LOOKUP.
- LOOKUP:
  - cache_en=1, cache_wrt=0, cache_addr=addr_q, cache_wdata=0.
  - Go to CHECK.
- CHECK: cache outputs are valid this cycle.
  - cache_hit=1: data_q=cache_rdata, hit_count+1, go to RESP.
  - Otherwise: miss_count+1, go to MEM_REQ.
- MEM_REQ:
  - mem_read=1, mem_address=addr_q.
  - Hold while mem_waitrequest=1; on an edge with mem_waitrequest=0, go to MEM_WAIT.
- MEM_WAIT:
  - mem_read=0.
  - On mem_readdatavalid=1: data_q=mem_readdata, go to FILL.
  - No timeout; waits indefinitely.
  - mem_readdatavalid in any state other than MEM_WAIT is ignored.
- FILL:
  - cache_en=1, cache_wrt=1, cache_addr=addr_q, cache_wdata=data_q.
  - Go to RESP; the cache result for this write is ignored.
- RESP:
  - resp_valid=1, resp_data=data_q.
  - Hold until resp_ready=1 at an edge, then go to IDLE.
  - resp_data is stable while resp_valid=1.
- Output drive:
  - cache_en, cache_wrt and mem_read are decoded from state.
  - resp_data is held constant outside RESP.
  - cache_en=0 in every state other than LOOKUP/FILL.
- Latency, with the accept edge as T0:
  - Hit: resp_valid high after edge T0+2.
  - Miss, zero waitrequest, readdatavalid in the first MEM_WAIT cycle: resp_valid high after edge T0+5.
- Counters saturate at 2^CNT_W-1 and never wrap.
- req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored (no queuing).

Test Plan:
- Bench instantiates cache_ro (BIT_INDEX=5) downstream and a memory model returning mem[a]=a^32'hA5A5_0000.
- Cold miss:
  - Stimulus: reset, req_addr=3, waitrequest=0, 1-cycle data latency.
  - Required response: mem_read asserted for exactly one cycle with mem_address=3; one FILL write to the cache; resp_data=32'hA5A5_0003 after edge T0+5; miss_count=1, hit_count=0.
- Hit after fill:
  - Stimulus: req_addr=3 again.
  - Required response: no mem_read; resp_data=32'hA5A5_0003 after edge T0+2; hit_count=1.
- Conflict eviction:
  - Stimulus: read 32, then 64, then 32.
  - Required response: three misses with fresh memory reads; resp_data=32'hA5A5_0020, 32'hA5A5_0040, 32'hA5A5_0020; miss_count=4 cumulative.
- Backpressure:
  - Stimulus: waitrequest=1 for 4 cycles; readdatavalid 6 cycles later; resp_ready low for 3 cycles.
  - Required response: mem_read and mem_address stable through the stall; resp_valid and resp_data held; req_ready=0 throughout; req_valid pulses are ignored.
- Reset mid-miss:
  - Stimulus: assert rst=0 in MEM_WAIT; release; the memory model then fires readdatavalid.
  - Required response: outputs 0 immediately; req_ready=1; no cache write or resp_valid; counters=0.
- Saturation:
  - Stimulus: CNT_W=2, 5 hits to addr 0.
  - Required response: hit_count stays at 3.
